cache_mem_arbiter: RTL and testbench



---
 rtl/cache_mem_arbiter.sv | 195 +++++++++++++++++++
 tb/tb_cache_mem_arbiter.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_mem_arbiter.sv
// Round-robin arbiter sharing one main-memory refill port between the L1 I-cache and D-cache.
// Define CACHE_ARB_PERF_CNT_EN to build the grant/conflict performance counters.
module cache_mem_arbiter #(
  parameter int LINE_W  = 128,
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 1023
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              ic_req_i,
  input  logic [ADDR_W-1:0] ic_addr_i,
  output logic              ic_ack_o,
  output logic [LINE_W-1:0] ic_rdata_o,
  input  logic              dc_req_i,
  input  logic              dc_we_i,
  input  logic [ADDR_W-1:0] dc_addr_i,
  input  logic [LINE_W-1:0] dc_wdata_i,
  output logic              dc_ack_o,
  output logic [LINE_W-1:0] dc_rdata_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [LINE_W-1:0] mem_wdata_o,
  input  logic              mem_ready_i,
  input  logic [LINE_W-1:0] mem_rdata_i,
  output logic [1:0]        grant_o,
  output logic              err_o,
  output logic [31:0]       ic_grant_cnt_o,
  output logic [31:0]       dc_grant_cnt_o,
  output logic [31:0]       conflict_cnt_o
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] WD_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t           state_r;
  logic             last_dc_r;
  logic [CNT_W-1:0] wd_cnt_r;
  logic             grant_ic_s;
  logic             grant_dc_s;
  logic             wd_expire_s;

  // Arbitration decision: a lone requester wins, a conflict goes to whoever was not granted last.
  always_comb begin
    grant_ic_s = 1'b0;
    grant_dc_s = 1'b0;
    if (state_r == ST_IDLE) begin
      if (ic_req_i && dc_req_i) begin
        if (last_dc_r) begin
          grant_ic_s = 1'b1;
        end else begin
          grant_dc_s = 1'b1;
        end
      end else if (ic_req_i) begin
        grant_ic_s = 1'b1;
      end else if (dc_req_i) begin
        grant_dc_s = 1'b1;
      end else begin
        grant_ic_s = 1'b0;
        grant_dc_s = 1'b0;
      end
    end else begin
      grant_ic_s = 1'b0;
      grant_dc_s = 1'b0;
    end
  end

  // A zero TIMEOUT disables the watchdog entirely.
  assign wd_expire_s = (TIMEOUT != 0) && (wd_cnt_r == WD_LAST);

  // Transaction FSM with all memory-side and cache-side outputs registered.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r     <= ST_IDLE;
      last_dc_r   <= 1'b0;
      wd_cnt_r    <= '0;
      ic_ack_o    <= 1'b0;
      dc_ack_o    <= 1'b0;
      ic_rdata_o  <= '0;
      dc_rdata_o  <= '0;
      mem_req_o   <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
      grant_o     <= 2'b00;
      err_o       <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          ic_ack_o <= 1'b0;
          dc_ack_o <= 1'b0;
          if (grant_ic_s || grant_dc_s) begin
            state_r     <= ST_BUSY;
            mem_req_o   <= 1'b1;
            grant_o     <= {grant_dc_s, grant_ic_s};
            last_dc_r   <= grant_dc_s;
            mem_we_o    <= grant_dc_s & dc_we_i;
            mem_addr_o  <= grant_dc_s ? dc_addr_i : ic_addr_i;
            mem_wdata_o <= grant_dc_s ? dc_wdata_i : '0;
            wd_cnt_r    <= '0;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_BUSY: begin
          // Ready takes priority over a watchdog expiry in the same cycle.
          if (mem_ready_i) begin
            if (grant_o[0]) begin
              ic_rdata_o <= mem_rdata_i;
            end else begin
              dc_rdata_o <= mem_rdata_i;
            end
            state_r   <= ST_RESP;
            mem_req_o <= 1'b0;
            ic_ack_o  <= grant_o[0];
            dc_ack_o  <= grant_o[1];
          end else if (wd_expire_s) begin
            if (grant_o[0]) begin
              ic_rdata_o <= '0;
            end else begin
              dc_rdata_o <= '0;
            end
            err_o     <= 1'b1;
            state_r   <= ST_RESP;
            mem_req_o <= 1'b0;
            ic_ack_o  <= grant_o[0];
            dc_ack_o  <= grant_o[1];
          end else begin
            wd_cnt_r <= wd_cnt_r + 1'b1;
          end
        end
        ST_RESP: begin
          ic_ack_o  <= 1'b0;
          dc_ack_o  <= 1'b0;
          mem_req_o <= 1'b0;
          grant_o   <= 2'b00;
          state_r   <= ST_IDLE;
        end
        default: begin
          ic_ack_o  <= 1'b0;
          dc_ack_o  <= 1'b0;
          mem_req_o <= 1'b0;
          grant_o   <= 2'b00;
          state_r   <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef CACHE_ARB_PERF_CNT_EN
  logic [31:0] ic_cnt_r;
  logic [31:0] dc_cnt_r;
  logic [31:0] cf_cnt_r;

  // Wrapping grant and conflict counters, bumped on each IDLE-to-BUSY grant.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ic_cnt_r <= 32'd0;
      dc_cnt_r <= 32'd0;
      cf_cnt_r <= 32'd0;
    end else begin
      if (grant_ic_s) begin
        ic_cnt_r <= ic_cnt_r + 32'd1;
      end else begin
        ic_cnt_r <= ic_cnt_r;
      end
      if (grant_dc_s) begin
        dc_cnt_r <= dc_cnt_r + 32'd1;
      end else begin
        dc_cnt_r <= dc_cnt_r;
      end
      if ((grant_ic_s || grant_dc_s) && ic_req_i && dc_req_i) begin
        cf_cnt_r <= cf_cnt_r + 32'd1;
      end else begin
        cf_cnt_r <= cf_cnt_r;
      end
    end
  end

  assign ic_grant_cnt_o = ic_cnt_r;
  assign dc_grant_cnt_o = dc_cnt_r;
  assign conflict_cnt_o = cf_cnt_r;
`else
  assign ic_grant_cnt_o = 32'd0;
  assign dc_grant_cnt_o = 32'd0;
  assign conflict_cnt_o = 32'd0;
`endif

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed self-checking bench for cache_mem_arbiter (watchdog TIMEOUT set to 8).
module tb_cache_mem_arbiter;

`ifdef CACHE_ARB_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  localparam logic [127:0] L1 = 128'h0011_2233_4455_6677_8899_AABB_CCDD_EEFF;
  localparam logic [127:0] WB = 128'hDEAD_0000_1111_2222_3333_4444_5555_BEEF;
  localparam logic [127:0] L2 = 128'h5A5A_5A5A_0000_FFFF_1234_5678_9ABC_DEF0;
  localparam logic [127:0] L3 = 128'hC0DE_C0DE_0101_0202_0303_0404_0505_0606;
  localparam logic [127:0] L4 = 128'h4444_4444_AAAA_5555_0F0F_F0F0_1357_2468;
  localparam logic [127:0] L5 = 128'h5555_0000_5555_0000_5555_0000_5555_0001;
  localparam logic [127:0] L6 = 128'h6666_6666_6666_6666_6666_6666_6666_6666;
  localparam logic [127:0] L7 = 128'h7777_1111_7777_2222_7777_3333_7777_4444;

  logic         clk = 1'b0;
  logic         rst_i = 1'b1;
  logic         ic_req_i = 1'b0;
  logic [31:0]  ic_addr_i = 32'd0;
  logic         ic_ack_o;
  logic [127:0] ic_rdata_o;
  logic         dc_req_i = 1'b0;
  logic         dc_we_i = 1'b0;
  logic [31:0]  dc_addr_i = 32'd0;
  logic [127:0] dc_wdata_i = 128'd0;
  logic         dc_ack_o;
  logic [127:0] dc_rdata_o;
  logic         mem_req_o;
  logic         mem_we_o;
  logic [31:0]  mem_addr_o;
  logic [127:0] mem_wdata_o;
  logic         mem_ready_i = 1'b0;
  logic [127:0] mem_rdata_i = 128'd0;
  logic [1:0]   grant_o;
  logic         err_o;
  logic [31:0]  ic_grant_cnt_o;
  logic [31:0]  dc_grant_cnt_o;
  logic [31:0]  conflict_cnt_o;

  int compared = 0;
  int mismatched = 0;
  int e_ic = 0;
  int e_dc = 0;
  int e_cf = 0;
  int ic_acks = 0;
  int dc_acks = 0;
  int acks_before;
  int lat;
  logic [1:0] order [4];

  cache_mem_arbiter #(.LINE_W(128), .ADDR_W(32), .TIMEOUT(8)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .ic_req_i(ic_req_i), .ic_addr_i(ic_addr_i), .ic_ack_o(ic_ack_o), .ic_rdata_o(ic_rdata_o),
    .dc_req_i(dc_req_i), .dc_we_i(dc_we_i), .dc_addr_i(dc_addr_i), .dc_wdata_i(dc_wdata_i),
    .dc_ack_o(dc_ack_o), .dc_rdata_o(dc_rdata_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_ready_i(mem_ready_i), .mem_rdata_i(mem_rdata_i),
    .grant_o(grant_o), .err_o(err_o),
    .ic_grant_cnt_o(ic_grant_cnt_o), .dc_grant_cnt_o(dc_grant_cnt_o), .conflict_cnt_o(conflict_cnt_o)
  );

  always #5 clk = ~clk;

  // Ack pulse tally, sampled mid-cycle.
  always @(negedge clk) begin
    if (ic_ack_o) ic_acks++;
    if (dc_ack_o) dc_acks++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_cnt(input string tag);
    chk({tag, "_ic_cnt"}, ic_grant_cnt_o, PERF ? e_ic : 0);
    chk({tag, "_dc_cnt"}, dc_grant_cnt_o, PERF ? e_dc : 0);
    chk({tag, "_cf_cnt"}, conflict_cnt_o, PERF ? e_cf : 0);
  endtask

  initial begin
    order[0] = 2'b10; order[1] = 2'b01; order[2] = 2'b10; order[3] = 2'b01;

    // Reset state
    rst_i = 1'b1;
    tick(); tick();
    rst_i = 1'b0;
    chk("rst_mem_req", mem_req_o, 0);
    chk("rst_grant", grant_o, 0);
    chk("rst_err", err_o, 0);
    chk("rst_acks", {ic_ack_o, dc_ack_o}, 0);
    chk("rst_rdata", ic_rdata_o | dc_rdata_o, 0);
    chk("rst_mem_addr", mem_addr_o, 0);
    chk_cnt("rst");

    // I-cache refill, memory ready in the fourth BUSY cycle
    ic_req_i = 1'b1; ic_addr_i = 32'h0000_0040;
    tick(); e_ic++;
    chk("s1_mem_req", mem_req_o, 1);
    chk("s1_grant", grant_o, 2'b01);
    chk("s1_mem_addr", mem_addr_o, 32'h40);
    chk("s1_mem_we", mem_we_o, 0);
    repeat (3) tick();
    chk("s1_no_early_ack", ic_acks, 0);
    chk("s1_req_held", mem_req_o, 1);
    mem_ready_i = 1'b1; mem_rdata_i = L1;
    tick();
    chk("s1_ic_ack", ic_ack_o, 1);
    chk("s1_ic_rdata", ic_rdata_o, L1);
    chk("s1_mem_req_low", mem_req_o, 0);
    mem_ready_i = 1'b0; mem_rdata_i = 128'd0;
    tick();
    chk("s1_ack_single", ic_ack_o, 0);
    chk("s1_grant_idle", grant_o, 0);
    ic_req_i = 1'b0;
    chk("s1_dc_ack_never", dc_acks, 0);
    chk_cnt("s1");

    // D-cache write-back, ready in the first BUSY cycle
    dc_req_i = 1'b1; dc_we_i = 1'b1; dc_addr_i = 32'h100; dc_wdata_i = WB;
    lat = 0;
    tick(); lat++; e_dc++;
    chk("s2_grant", grant_o, 2'b10);
    chk("s2_mem_we", mem_we_o, 1);
    chk("s2_mem_addr", mem_addr_o, 32'h100);
    chk("s2_mem_wdata", mem_wdata_o, WB);
    mem_ready_i = 1'b1; mem_rdata_i = L2;
    tick(); lat++;
    chk("s2_dc_ack", dc_ack_o, 1);
    chk("s2_latency_edges", lat, 2);
    chk("s2_ic_rdata_hold", ic_rdata_o, L1);
    mem_ready_i = 1'b0;
    tick();
    dc_req_i = 1'b0; dc_we_i = 1'b0;
    chk("s2_grant_idle", grant_o, 0);
    chk_cnt("s2");

    // Simultaneous requests after reset, both re-requesting after each ack
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0; e_ic = 0; e_dc = 0; e_cf = 0;
    ic_req_i = 1'b1; ic_addr_i = 32'h80;
    dc_req_i = 1'b1; dc_addr_i = 32'h180;
    mem_ready_i = 1'b1; mem_rdata_i = L3;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("s3_grant", grant_o, order[i]);
      chk("s3_mem_addr", mem_addr_o, (order[i] == 2'b10) ? 32'h180 : 32'h80);
      tick();
      chk("s3_ack", {dc_ack_o, ic_ack_o}, order[i]);
      tick();
      chk("s3_idle_gap", grant_o, 0);
    end
    ic_req_i = 1'b0; dc_req_i = 1'b0; mem_ready_i = 1'b0;
    e_ic = 2; e_dc = 2; e_cf = 4;
    chk("s3_ic_rdata", ic_rdata_o, L3);
    chk_cnt("s3");

    // Ready arrives on the very cycle the watchdog would fire
    ic_req_i = 1'b1; ic_addr_i = 32'h400;
    tick(); e_ic++;
    repeat (7) tick();
    chk("s3b_still_busy", mem_req_o, 1);
    mem_ready_i = 1'b1; mem_rdata_i = L4;
    tick();
    chk("s3b_ack", ic_ack_o, 1);
    chk("s3b_rdata", ic_rdata_o, L4);
    chk("s3b_no_err", err_o, 0);
    mem_ready_i = 1'b0;
    tick();
    ic_req_i = 1'b0;

    // Memory never ready: watchdog abort after 8 BUSY cycles
    ic_req_i = 1'b1; ic_addr_i = 32'h500;
    acks_before = ic_acks;
    tick(); e_ic++;
    repeat (7) tick();
    chk("s4_no_early_ack", ic_acks, acks_before);
    chk("s4_busy8_req", mem_req_o, 1);
    tick();
    chk("s4_ack_cycle9", ic_ack_o, 1);
    chk("s4_rdata_zero", ic_rdata_o, 0);
    chk("s4_err", err_o, 1);
    tick();
    ic_req_i = 1'b0;
    dc_req_i = 1'b1; dc_we_i = 1'b0; dc_addr_i = 32'h600;
    tick(); e_dc++;
    mem_ready_i = 1'b1; mem_rdata_i = L5;
    tick();
    chk("s4_dc_ack", dc_ack_o, 1);
    chk("s4_dc_rdata", dc_rdata_o, L5);
    mem_ready_i = 1'b0;
    tick();
    dc_req_i = 1'b0;
    chk("s4_err_sticky", err_o, 1);
    chk_cnt("s4");

    // Reset two cycles into BUSY, then a stray ready in IDLE
    ic_req_i = 1'b1; ic_addr_i = 32'h700;
    tick(); tick();
    rst_i = 1'b1;
    acks_before = ic_acks;
    tick();
    rst_i = 1'b0; ic_req_i = 1'b0; e_ic = 0; e_dc = 0; e_cf = 0;
    chk("s5_mem_req", mem_req_o, 0);
    chk("s5_grant", grant_o, 0);
    chk("s5_err_cleared", err_o, 0);
    mem_ready_i = 1'b1; mem_rdata_i = L6;
    tick();
    mem_ready_i = 1'b0;
    tick();
    chk("s5_no_ack", ic_acks, acks_before);
    chk("s5_idle_req", mem_req_o, 0);
    chk("s5_idle_grant", grant_o, 0);
    chk("s5_rdata_untouched", ic_rdata_o, 0);
    ic_req_i = 1'b1; ic_addr_i = 32'h800;
    tick(); e_ic++;
    chk("s5_new_grant", grant_o, 2'b01);
    chk("s5_new_addr", mem_addr_o, 32'h800);
    mem_ready_i = 1'b1; mem_rdata_i = L7;
    tick();
    chk("s5_new_ack", ic_ack_o, 1);
    chk("s5_new_rdata", ic_rdata_o, L7);
    mem_ready_i = 1'b0;
    tick();
    ic_req_i = 1'b0;
    chk_cnt("s5");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
